afifo_unpacker: RTL and testbench



---
 rtl/afifo_pkg.sv | 19 +
 rtl/afifo_unpacker.sv | 87 ++++++++
 tb/tb_afifo_unpacker.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// Shared types and width helpers for the async-FIFO width converters.
// Kept small so packers and unpackers can reuse the same state encoding.
package afifo_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Index width for a slice counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/afifo_unpacker.sv
// Read-side width converter: pops DW-bit words from a show-ahead FIFO and
// emits them as DW/OW beats of OW bits, least-significant slice first.
module afifo_unpacker
  import afifo_pkg::*;
#(
  parameter int DW = 128,
  parameter int OW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fifo_rempty,
  input  logic [DW-1:0] fifo_q,
  output logic          fifo_re,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last,
  output logic [CW-1:0] word_cnt
);

  localparam int R  = DW / OW;
  localparam int IW = idx_width(R);
  localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);

  if ((DW % OW) != 32'sd0) begin : g_bad_ratio
    $error("afifo_unpacker: DW must be an integer multiple of OW");
  end

  logic [DW-1:0] hold_r;
  logic [IW-1:0] idx_r;
  state_e        state_r;
  logic [CW-1:0] word_cnt_r;

  logic          last_s;
  logic          fire_s;
  logic          pop_s;

  // Beat presentation and handshake decode; pops are suppressed under reset
  // so a word is never taken from the FIFO and then thrown away.
  always_comb begin
    m_valid  = 1'b0;
    last_s   = 1'b0;
    fire_s   = 1'b0;
    pop_s    = 1'b0;
    m_valid  = (state_r == ACTIVE);
    last_s   = (idx_r == LAST_IDX);
    fire_s   = m_valid & m_ready;
    if (reset) begin
      pop_s = 1'b0;
    end else begin
      pop_s = !fifo_rempty & ((state_r == EMPTY) | (fire_s & last_s));
    end
  end

  assign m_data   = hold_r[idx_r * OW +: OW];
  assign m_last   = m_valid & last_s;
  assign fifo_re  = pop_s;
  assign word_cnt = word_cnt_r;

  // Word holding register, slice index, state and popped-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r     <= {DW{1'b0}};
      idx_r      <= {IW{1'b0}};
      state_r    <= EMPTY;
      word_cnt_r <= {CW{1'b0}};
    end else if (pop_s) begin
      hold_r     <= fifo_q;
      idx_r      <= {IW{1'b0}};
      state_r    <= ACTIVE;
      word_cnt_r <= word_cnt_r + CW'(1'b1);
    end else if (fire_s) begin
      if (!last_s) begin
        idx_r <= idx_r + IW'(1'b1);
      end else begin
        state_r <= EMPTY;
      end
    end else begin
      hold_r     <= hold_r;
      idx_r      <= idx_r;
      state_r    <= state_r;
      word_cnt_r <= word_cnt_r;
    end
  end

endmodule

// File: tb/tb_afifo_unpacker.sv
// Directed bench for afifo_unpacker: a 128->32 instance and a 128->128
// pass-through instance, each fed from a queue acting as a show-ahead FIFO.
module tb_afifo_unpacker;

  logic         clk;
  logic         reset;

  logic         fifo_rempty_a;
  logic [127:0] fifo_q_a;
  logic         fifo_re_a;
  logic         m_valid_a;
  logic         m_ready_a;
  logic [31:0]  m_data_a;
  logic         m_last_a;
  logic [15:0]  word_cnt_a;

  logic         fifo_rempty_b;
  logic [127:0] fifo_q_b;
  logic         fifo_re_b;
  logic         m_valid_b;
  logic         m_ready_b;
  logic [127:0] m_data_b;
  logic         m_last_b;
  logic [15:0]  word_cnt_b;

  logic [127:0] qa[$];
  logic [127:0] qb[$];

  int total;
  int bad;

  afifo_unpacker #(.DW(128), .OW(32), .CW(16)) dut_a (
    .clk(clk), .reset(reset),
    .fifo_rempty(fifo_rempty_a), .fifo_q(fifo_q_a), .fifo_re(fifo_re_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .m_last(m_last_a), .word_cnt(word_cnt_a)
  );

  afifo_unpacker #(.DW(128), .OW(128), .CW(16)) dut_b (
    .clk(clk), .reset(reset),
    .fifo_rempty(fifo_rempty_b), .fifo_q(fifo_q_b), .fifo_re(fifo_re_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .m_last(m_last_b), .word_cnt(word_cnt_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bv(input int k, input int j);
    return 32'h1000_0000 + 32'(k * 256 + j);
  endfunction

  function automatic logic [127:0] wv(input int k);
    return {bv(k, 3), bv(k, 2), bv(k, 1), bv(k, 0)};
  endfunction

  // One clock: retire popped words, cross the edge, re-drive FIFO outputs.
  task automatic cyc();
    #1;
    if (fifo_re_a && qa.size() > 0) void'(qa.pop_front());
    if (fifo_re_b && qb.size() > 0) void'(qb.pop_front());
    @(posedge clk);
    @(negedge clk);
    fifo_rempty_a = (qa.size() == 0);
    fifo_q_a      = (qa.size() > 0) ? qa[0] : 128'h0;
    fifo_rempty_b = (qb.size() == 0);
    fifo_q_b      = (qb.size() > 0) ? qb[0] : 128'h0;
    #1;
  endtask

  task automatic do_reset();
    qa.delete();
    qb.delete();
    m_ready_a = 1'b0;
    m_ready_b = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    qa.delete();
    qa.push_back(wv(1));
    m_ready_a = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (fifo_re_a !== 1'b0 || m_valid_a !== 1'b0 || word_cnt_a !== 16'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d re=%b valid=%b cnt=%0d required re=0 valid=0 cnt=0",
                 i, fifo_re_a, m_valid_a, word_cnt_a);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (fifo_re_a !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_pop re=%b required 1", fifo_re_a);
    end
    for (int i = 0; i < 6; i++) cyc();
  endtask

  task automatic test_single_word();
    logic [31:0] exp_beat [4];
    exp_beat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_reset();
    m_ready_a = 1'b1;
    qa.push_back(128'h44444444_33333333_22222222_11111111);
    cyc();
    total++;
    if (fifo_re_a !== 1'b1 || m_valid_a !== 1'b0) begin
      bad++;
      $display("FAIL single_pop re=%b valid=%b required re=1 valid=0", fifo_re_a, m_valid_a);
    end
    for (int j = 0; j < 4; j++) begin
      cyc();
      total++;
      if (m_valid_a !== 1'b1 || m_data_a !== exp_beat[j] || m_last_a !== (j == 3)) begin
        bad++;
        $display("FAIL single_beat%0d valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                 j, m_valid_a, m_data_a, m_last_a, exp_beat[j], (j == 3));
      end
    end
    cyc();
    total++;
    if (m_valid_a !== 1'b0 || word_cnt_a !== 16'd1) begin
      bad++;
      $display("FAIL single_after valid=%b cnt=%0d required valid=0 cnt=1", m_valid_a, word_cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    m_ready_a = 1'b1;
    for (int k = 0; k < 3; k++) qa.push_back(wv(k));
    cyc();
    for (int b = 1; b <= 12; b++) begin
      cyc();
      total++;
      if (m_valid_a !== 1'b1 || m_data_a !== bv((b - 1) / 4, (b - 1) % 4) ||
          m_last_a !== (b % 4 == 0) || fifo_re_a !== (b == 4 || b == 8)) begin
        bad++;
        $display("FAIL b2b_beat%0d valid=%b data=%h last=%b re=%b required valid=1 data=%h last=%b re=%b",
                 b, m_valid_a, m_data_a, m_last_a, fifo_re_a, bv((b - 1) / 4, (b - 1) % 4),
                 (b % 4 == 0), (b == 4 || b == 8));
      end
    end
    cyc();
    total++;
    if (m_valid_a !== 1'b0 || word_cnt_a !== 16'd3) begin
      bad++;
      $display("FAIL b2b_after valid=%b cnt=%0d required valid=0 cnt=3", m_valid_a, word_cnt_a);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    int          cycles;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      qa.push_back(wv(k + 20));
      for (int j = 0; j < 4; j++) begin
        exp_data.push_back(bv(k + 20, j));
        exp_last.push_back(j == 3);
      end
    end
    cyc();
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    prev_last  = 1'b0;
    cycles     = 0;
    while (exp_data.size() > 0 && cycles < 3000) begin
      m_ready_a = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (fifo_re_a && fifo_rempty_a) begin
        bad++;
        $display("FAIL bp_pop_empty re=%b rempty=%b required no pop while empty", fifo_re_a, fifo_rempty_a);
      end
      if (prev_stall) begin
        total++;
        if (m_valid_a !== 1'b1 || m_data_a !== prev_data || m_last_a !== prev_last) begin
          bad++;
          $display("FAIL bp_stable valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   m_valid_a, m_data_a, m_last_a, prev_data, prev_last);
        end
      end
      if (m_valid_a && m_ready_a) begin
        total++;
        if (m_data_a !== exp_data[0] || m_last_a !== exp_last[0]) begin
          bad++;
          $display("FAIL bp_beat data=%h last=%b required data=%h last=%b",
                   m_data_a, m_last_a, exp_data[0], exp_last[0]);
        end
        void'(exp_data.pop_front());
        void'(exp_last.pop_front());
      end
      prev_stall = m_valid_a && !m_ready_a;
      prev_data  = m_data_a;
      prev_last  = m_last_a;
      cyc();
      cycles++;
    end
    total++;
    if (exp_data.size() != 0) begin
      bad++;
      $display("FAIL bp_timeout remaining=%0d required 0", exp_data.size());
    end
    total++;
    if (word_cnt_a !== 16'd100 || m_valid_a !== 1'b0) begin
      bad++;
      $display("FAIL bp_count cnt=%0d valid=%b required cnt=100 valid=0", word_cnt_a, m_valid_a);
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    m_ready_a = 1'b1;
    qa.push_back(wv(10));
    qa.push_back(wv(11));
    cyc();
    cyc();
    cyc();
    total++;
    if (m_valid_a !== 1'b1 || m_data_a !== bv(10, 1)) begin
      bad++;
      $display("FAIL mid_beat2 valid=%b data=%h required valid=1 data=%h", m_valid_a, m_data_a, bv(10, 1));
    end
    reset = 1'b1;
    cyc();
    total++;
    if (m_valid_a !== 1'b0 || fifo_re_a !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset valid=%b re=%b required valid=0 re=0", m_valid_a, fifo_re_a);
    end
    reset = 1'b0;
    #1;
    total++;
    if (fifo_re_a !== 1'b1) begin
      bad++;
      $display("FAIL mid_repop re=%b required 1", fifo_re_a);
    end
    cyc();
    total++;
    if (m_valid_a !== 1'b1 || m_data_a !== bv(11, 0) || m_last_a !== 1'b0 || word_cnt_a !== 16'd1) begin
      bad++;
      $display("FAIL mid_next valid=%b data=%h last=%b cnt=%0d required valid=1 data=%h last=0 cnt=1",
               m_valid_a, m_data_a, m_last_a, word_cnt_a, bv(11, 0));
    end
    for (int i = 0; i < 4; i++) cyc();
  endtask

  task automatic test_pass_through();
    do_reset();
    m_ready_b = 1'b1;
    for (int k = 0; k < 5; k++) qb.push_back(wv(k + 40));
    cyc();
    total++;
    if (fifo_re_b !== 1'b1 || m_valid_b !== 1'b0 || m_last_b !== 1'b0) begin
      bad++;
      $display("FAIL pt_pop re=%b valid=%b last=%b required re=1 valid=0 last=0", fifo_re_b, m_valid_b, m_last_b);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      total++;
      if (m_valid_b !== 1'b1 || m_data_b !== wv(k + 40) || m_last_b !== 1'b1 || fifo_re_b !== (k < 4)) begin
        bad++;
        $display("FAIL pt_beat%0d valid=%b data=%h last=%b re=%b required valid=1 data=%h last=1 re=%b",
                 k, m_valid_b, m_data_b, m_last_b, fifo_re_b, wv(k + 40), (k < 4));
      end
    end
    cyc();
    total++;
    if (m_valid_b !== 1'b0 || word_cnt_b !== 16'd5) begin
      bad++;
      $display("FAIL pt_after valid=%b cnt=%0d required valid=0 cnt=5", m_valid_b, word_cnt_b);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    clk = 1'b0;
    reset = 1'b1;
    m_ready_a = 1'b0;
    m_ready_b = 1'b0;
    fifo_rempty_a = 1'b1;
    fifo_q_a = 128'h0;
    fifo_rempty_b = 1'b1;
    fifo_q_b = 128'h0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_pass_through();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
